// File: rtl/posit_divsqrt_issue.sv
// Issue stage in front of PositDivSqrter16_0: tagged request FIFO, single outstanding op, held response.
// Optional special-operand bypass enabled by defining POSIT_SPECIAL_BYPASS_EN.
module posit_divsqrt_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int N          = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_req_valid,
  output logic                          io_req_ready,
  input  logic                          io_req_sqrt,
  input  logic [N-1:0]                  io_req_A,
  input  logic [N-1:0]                  io_req_B,
  input  logic [TAG_W-1:0]              io_req_tag,
  input  logic                          io_div_inReady,
  output logic                          io_div_inValid,
  output logic                          io_div_sqrtOp,
  output logic [N-1:0]                  io_div_A,
  output logic [N-1:0]                  io_div_B,
  input  logic                          io_div_diviValid,
  input  logic                          io_div_sqrtValid,
  input  logic                          io_div_invalidExc,
  input  logic [N-1:0]                  io_div_Q,
  output logic                          io_resp_valid,
  input  logic                          io_resp_ready,
  output logic [N-1:0]                  io_resp_Q,
  output logic                          io_resp_invalid,
  output logic                          io_resp_sqrt,
  output logic [TAG_W-1:0]              io_resp_tag,
  output logic [$clog2(FIFO_DEPTH):0]   io_fifo_count,
  output logic                          io_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]  FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} stateT;
  stateT state, stateNext;

  logic             memSqrt [FIFO_DEPTH];
  logic [N-1:0]     memA    [FIFO_DEPTH];
  logic [N-1:0]     memB    [FIFO_DEPTH];
  logic [TAG_W-1:0] memTag  [FIFO_DEPTH];

  logic [PW-1:0]    wrPtr, rdPtr;
  logic [PW:0]      count;
  logic             flightSqrt;
  logic [TAG_W-1:0] flightTag;
  logic [N-1:0]     respQ;
  logic             respInvalid, respSqrt;
  logic [TAG_W-1:0] respTag;

  logic             headSqrt;
  logic [N-1:0]     headA, headB;
  logic [TAG_W-1:0] headTag;
  logic             push, pop, issueFire, doneEvt;
  logic             bypassHit, bypassInv;
  logic [N-1:0]     bypassQ;

  assign headSqrt = memSqrt[rdPtr];
  assign headA    = memA[rdPtr];
  assign headB    = memB[rdPtr];
  assign headTag  = memTag[rdPtr];

  assign io_req_ready = (count != FULL);
  assign push      = io_req_valid && io_req_ready;
  assign issueFire = io_div_inValid && io_div_inReady;
  assign pop       = issueFire || ((state == ISSUE) && bypassHit);
  assign doneEvt   = flightSqrt ? io_div_sqrtValid : io_div_diviValid;

`ifdef POSIT_SPECIAL_BYPASS_EN
  // Zero divisor and negative radicand flag invalid; a NaR operand propagates quietly.
  always_comb begin
    bypassHit = 1'b0;
    bypassQ   = '0;
    bypassInv = 1'b0;
    if (headSqrt) begin
      if (headA == NAR) begin
        bypassHit = 1'b1; bypassQ = NAR;
      end else if (headA[N-1]) begin
        bypassHit = 1'b1; bypassQ = NAR; bypassInv = 1'b1;
      end
    end else begin
      if (headB == '0) begin
        bypassHit = 1'b1; bypassQ = NAR; bypassInv = 1'b1;
      end else if (headA == NAR || headB == NAR) begin
        bypassHit = 1'b1; bypassQ = NAR;
      end
    end
  end
`else
  assign bypassHit = 1'b0;
  assign bypassQ   = '0;
  assign bypassInv = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (count != '0) stateNext = ISSUE;
      ISSUE: if (bypassHit) stateNext = HOLD;
             else if (io_div_inReady) stateNext = WAIT;
      WAIT:  if (doneEvt) stateNext = HOLD;
      HOLD:  if (io_resp_ready) stateNext = (count != '0) ? ISSUE : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Entry storage needs no reset: it is only observed through the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      memSqrt[wrPtr] <= io_req_sqrt;
      memA[wrPtr]    <= io_req_A;
      memB[wrPtr]    <= io_req_B;
      memTag[wrPtr]  <= io_req_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      flightSqrt  <= 1'b0;
      flightTag   <= '0;
      respQ       <= '0;
      respInvalid <= 1'b0;
      respSqrt    <= 1'b0;
      respTag     <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);

      if (state == ISSUE) begin
        if (bypassHit) begin
          respQ       <= bypassQ;
          respInvalid <= bypassInv;
          respSqrt    <= headSqrt;
          respTag     <= headTag;
        end else if (io_div_inReady) begin
          flightSqrt <= headSqrt;
          flightTag  <= headTag;
        end
      end
      if (state == WAIT && doneEvt) begin
        respQ       <= io_div_Q;
        respInvalid <= io_div_invalidExc;
        respSqrt    <= flightSqrt;
        respTag     <= flightTag;
      end
    end
  end

  assign io_div_inValid  = (state == ISSUE) && !bypassHit;
  assign io_div_sqrtOp   = (state == ISSUE) ? headSqrt : 1'b0;
  assign io_div_A        = (state == ISSUE) ? headA : '0;
  assign io_div_B        = (state == ISSUE) ? headB : '0;
  assign io_resp_valid   = (state == HOLD);
  assign io_resp_Q       = respQ;
  assign io_resp_invalid = respInvalid;
  assign io_resp_sqrt    = respSqrt;
  assign io_resp_tag     = respTag;
  assign io_fifo_count   = count;
  assign io_busy         = (state != IDLE) || (count != '0);

endmodule
